// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and constants for the clock divider
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Smallest divide ratio that still produces a clock with both phases.
  localparam int MIN_RATIO = 2;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - run/ratio handshake and divided clock outputs bundle
interface clk_div_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             div_req;
  logic [WIDTH-1:0] div_val;
  logic             div_ack;
  logic             div_err;
  logic             busy;
  logic             tick;
  logic             clock_out;

  modport master (
    output en, div_req, div_val,
    input  div_ack, div_err, busy, tick, clock_out
  );

  modport slave (
    input  en, div_req, div_val,
    output div_ack, div_err, busy, tick, clock_out
  );

endinterface

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter, wrap detect and registered clock_out/tick
module clk_div_core #(
  parameter int WIDTH = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             active,
  input  logic             run,
  input  logic [WIDTH-1:0] n,
  output logic             wrap,
  output logic             clock_out,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;

  // Wrap only means something while a period is in flight; cnt sits at 0 in IDLE.
  assign wrap     = active && (cnt == n - WIDTH'(1));
  assign cnt_next = (!active || wrap) ? '0 : cnt + WIDTH'(1);

  // Outputs are computed from the next count so they line up with cnt in the same cycle.
  always_ff @(posedge clock_in) begin
    if (reset || !run) begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      clock_out <= (cnt_next < (n >> 1));
      tick      <= (cnt_next == '0);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop FSM, divide ratio register and ratio-change handshake
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic          clock_in,
  input  logic          reset,
  clk_div_ctrl_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] n;
  logic             wrap;
  logic             active;
  logic             run;
  logic             req_live;
  logic             req_ok;
  logic             at_boundary;

  assign active      = (state != IDLE);
  assign run         = (state_next != IDLE);
  // A request is not re-examined on its own ack cycle; the requester drops it there.
  assign req_live    = bus.div_req && !bus.div_ack;
  assign req_ok      = (bus.div_val >= WIDTH'(MIN_RATIO));
  // Ratio may only change between periods, so the current one is never distorted.
  assign at_boundary = !active || wrap;

  // Next state: en keeps or resumes running; without en the period finishes, then idles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = bus.en ? RUN : IDLE;
      RUN,
      STOP:     state_next = bus.en ? RUN : (wrap ? IDLE : STOP);
      default:  state_next = IDLE;
    endcase
  end

  // State register, busy flag, ratio register and ack/err pulses.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= IDLE;
      bus.busy    <= 1'b0;
      n           <= WIDTH'(DIV_RESET);
      bus.div_ack <= 1'b0;
      bus.div_err <= 1'b0;
    end else begin
      state       <= state_next;
      bus.busy    <= run;
      bus.div_ack <= 1'b0;
      bus.div_err <= 1'b0;
      if (req_live && !req_ok) begin
        bus.div_ack <= 1'b1;
        bus.div_err <= 1'b1;
      end else if (req_live && at_boundary) begin
        n           <= bus.div_val;
        bus.div_ack <= 1'b1;
      end
    end
  end

  clk_div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock_in  (clock_in),
    .reset     (reset),
    .active    (active),
    .run       (run),
    .n         (n),
    .wrap      (wrap),
    .clock_out (bus.clock_out),
    .tick      (bus.tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

  localparam int WIDTH     = 8;
  localparam int DIV_RESET = 3;

  logic clk = 1'b0;
  logic reset;

  clk_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

  clk_div_ctrl #(
    .WIDTH     (WIDTH),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .clock_in (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: busy flag, position within the output period, ratio, output pulses.
  logic m_busy, m_co, m_tick, m_ack, m_err;
  int   m_pos, m_n;

  function automatic logic [4:0] dut_outs();
    return {bus.clock_out, bus.tick, bus.div_ack, bus.div_err, bus.busy};
  endfunction

  function automatic logic [4:0] model_outs();
    return {m_co, m_tick, m_ack, m_err, m_busy};
  endfunction

  // Advance the model by one clock using the inputs now applied, then clock the DUT.
  task automatic step();
    logic live, last, nb, nack, nerr;
    int   nn, np, v;
    if (reset) begin
      m_busy = 0; m_pos = 0; m_n = DIV_RESET;
      m_co = 0; m_tick = 0; m_ack = 0; m_err = 0;
    end else begin
      v    = int'(bus.div_val);
      live = bus.div_req && !m_ack;
      last = m_busy && (m_pos == m_n - 1);
      nn = m_n; nack = 0; nerr = 0;
      if (live) begin
        if (v < 2) begin
          nack = 1; nerr = 1;
        end else if (!m_busy || last) begin
          nack = 1; nn = v;
        end
      end
      nb = m_busy ? (bus.en || !last) : bus.en;
      np = (nb && m_busy && !last) ? m_pos + 1 : 0;
      m_busy = nb; m_pos = np; m_n = nn;
      m_co   = nb && (np < nn / 2);
      m_tick = nb && (np == 0);
      m_ack  = nack; m_err = nerr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.en = 1'b0; bus.div_req = 1'b0; bus.div_val = '0;
    step();
    step();
    n_cmp++;
    if (dut_outs() !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 00000", dut_outs());
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (dut_outs() !== 5'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b want 00000", dut_outs());
    end
  endtask

  task automatic test_div3();
    logic e;
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      e = (i % 3 == 0);
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.busy} !== {e, e, 1'b1}) begin
        n_bad++; $display("FAIL div3_cycle%0d: got co/tick/busy %b want %b", i,
                          {bus.clock_out, bus.tick, bus.busy}, {e, e, 1'b1});
      end
    end
  endtask

  task automatic test_invalid();
    logic e;
    bus.div_req = 1'b1; bus.div_val = 8'd1;
    step();
    n_cmp++;
    if ({bus.div_ack, bus.div_err} !== 2'b11) begin
      n_bad++; $display("FAIL invalid_ack: got ack/err %b want 11", {bus.div_ack, bus.div_err});
    end
    bus.div_req = 1'b0;
    for (int i = 1; i < 7; i++) begin
      step();
      e = (i % 3 == 0);
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.div_ack} !== {e, e, 1'b0}) begin
        n_bad++; $display("FAIL invalid_keeps_div3_%0d: got %b want %b", i,
                          {bus.clock_out, bus.tick, bus.div_ack}, {e, e, 1'b0});
      end
    end
  endtask

  task automatic test_ratio_change();
    logic e;
    for (int k = 0; k < 6 && m_pos != 0; k++) step();
    step();
    bus.div_req = 1'b1; bus.div_val = 8'd4;
    step();
    n_cmp++;
    if ({bus.clock_out, bus.tick, bus.div_ack} !== 3'b000) begin
      n_bad++; $display("FAIL change_no_truncate: got %b want 000",
                        {bus.clock_out, bus.tick, bus.div_ack});
    end
    step();
    n_cmp++;
    if ({bus.clock_out, bus.tick, bus.div_ack, bus.div_err} !== 4'b1110) begin
      n_bad++; $display("FAIL change_ack_with_tick: got %b want 1110",
                        {bus.clock_out, bus.tick, bus.div_ack, bus.div_err});
    end
    bus.div_req = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      e = ((i % 4) < 2);
      n_cmp++;
      if ({bus.clock_out, bus.tick} !== {e, (i % 4 == 0)}) begin
        n_bad++; $display("FAIL div4_cycle%0d: got %b want %b", i,
                          {bus.clock_out, bus.tick}, {e, (i % 4 == 0)});
      end
    end
  endtask

  task automatic test_stop();
    bus.div_req = 1'b1; bus.div_val = 8'd5;
    for (int k = 0; k < 10 && !m_ack; k++) step();
    n_cmp++;
    if ({bus.div_ack, bus.tick} !== 2'b11) begin
      n_bad++; $display("FAIL set5_ack: got ack/tick %b want 11", {bus.div_ack, bus.tick});
    end
    bus.div_req = 1'b0; bus.en = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      n_cmp++;
      if ({bus.clock_out, bus.busy} !== {(i < 2), 1'b1}) begin
        n_bad++; $display("FAIL stop_cycle%0d: got co/busy %b want %b", i,
                          {bus.clock_out, bus.busy}, {(i < 2), 1'b1});
      end
    end
    step();
    n_cmp++;
    if (dut_outs() !== 5'b0) begin
      n_bad++; $display("FAIL stop_idle: got %b want 00000", dut_outs());
    end
  endtask

  task automatic test_reset_mid();
    bus.div_req = 1'b1; bus.div_val = 8'd6;
    step();
    n_cmp++;
    if ({bus.div_ack, bus.div_err, bus.busy} !== 3'b100) begin
      n_bad++; $display("FAIL idle_set6: got %b want 100", {bus.div_ack, bus.div_err, bus.busy});
    end
    bus.div_req = 1'b0; bus.en = 1'b1;
    step(); step(); step();
    n_cmp++;
    if ({bus.clock_out, bus.tick, bus.busy} !== 3'b101) begin
      n_bad++; $display("FAIL div6_cnt2: got %b want 101", {bus.clock_out, bus.tick, bus.busy});
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (dut_outs() !== 5'b0) begin
      n_bad++; $display("FAIL reset_mid_period: got %b want 00000", dut_outs());
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if ({bus.clock_out, bus.tick} !== {(i % 3 == 0), (i % 3 == 0)}) begin
        n_bad++; $display("FAIL post_reset_div3_%0d: got %b want %b", i,
                          {bus.clock_out, bus.tick}, {(i % 3 == 0), (i % 3 == 0)});
      end
    end
  endtask

  task automatic test_same_cycle();
    bus.en = 1'b0;
    for (int k = 0; k < 20 && m_busy; k++) step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL same_cycle_idle_wait: got busy %b want 0", bus.busy);
    end
    bus.div_req = 1'b1; bus.div_val = 8'd2; bus.en = 1'b1;
    step();
    n_cmp++;
    if (dut_outs() !== 5'b11101) begin
      n_bad++; $display("FAIL same_cycle_start: got %b want 11101", dut_outs());
    end
    bus.div_req = 1'b0;
    for (int i = 1; i < 6; i++) begin
      step();
      n_cmp++;
      if (bus.clock_out !== (i % 2 == 0)) begin
        n_bad++; $display("FAIL div2_cycle%0d: got %b want %b", i, bus.clock_out, (i % 2 == 0));
      end
    end
  endtask

  task automatic test_random();
    reset = 1'b1; bus.en = 1'b0; bus.div_req = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bus.en = ~bus.en;
      if (bus.div_req && m_ack) begin
        bus.div_req = 1'b0;
      end else if (!bus.div_req && $urandom_range(0, 9) == 0) begin
        bus.div_req = 1'b1;
        bus.div_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1))
                                                   : 8'($urandom_range(2, 12));
      end
      reset = ($urandom_range(0, 149) == 0);
      if (reset) bus.div_req = 1'b0;
      step();
      n_cmp++;
      if (dut_outs() !== model_outs()) begin
        n_bad++; $display("FAIL random_cycle%0d: got co/tick/ack/err/busy %b want %b",
                          i, dut_outs(), model_outs());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b0; bus.div_req = 1'b0; bus.div_val = '0;
    m_busy = 0; m_pos = 0; m_n = DIV_RESET;
    m_co = 0; m_tick = 0; m_ack = 0; m_err = 0;
    test_reset();
    test_div3();
    test_invalid();
    test_ratio_change();
    test_stop();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
